// File: rtl/tx_sched.sv
// tx_sched: round-robin two-requester scheduler for tx frames.
// Optional macro TX_SCHED_RETX_EN: resend the held frame after RETX_CYCLES idle.
module tx_sched #(
    parameter int FRAME_CYCLES = 16200,
    parameter int GAP_CYCLES   = 1000,
    parameter int RETX_CYCLES  = 1000000
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         req_a_in,
    input  logic [161:0] frame_a_in,
    input  logic         req_b_in,
    input  logic [161:0] frame_b_in,
    output logic         grant_a_out,
    output logic         grant_b_out,
    output logic         trigger_out,
    output logic [161:0] val_out,
    output logic         busy_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [23:0] FRAME_LOAD = 24'(FRAME_CYCLES - 1);
    localparam logic [23:0] GAP_LOAD   = 24'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    // Reject parameter values the 24-bit counters cannot honour.
    if (FRAME_CYCLES < 1 || FRAME_CYCLES > 24'hFFFFFF ||
        GAP_CYCLES < 0 || GAP_CYCLES > 24'hFFFFFF ||
        RETX_CYCLES < 1) begin : g_bad_param
        $error("tx_sched: parameter out of range");
    end

    state_t         state_q, state_d;
    logic [23:0]    cnt_q, cnt_d;
    logic           last_b_q, last_b_d;
    logic [161:0]   val_d;
    logic           grant_a_d, grant_b_d, trig_d;
    logic           any_req, win_a;

    assign any_req = req_a_in | req_b_in;
    // A wins when alone, or on a tie when B was granted last.
    assign win_a   = req_a_in & (~req_b_in | last_b_q);

`ifdef TX_SCHED_RETX_EN
    localparam logic [31:0] RETX_LIM = 32'(RETX_CYCLES - 1);

    logic        sent_q, sent_d;
    logic [31:0] idle_q, idle_d;
    logic        retx_due;

    assign retx_due = (state_q == IDLE) && !any_req && sent_q && (idle_q == RETX_LIM);

    // Count consecutive request-free IDLE cycles, saturating at the resend point.
    always_comb begin
        idle_d = '0;
        if (state_q == IDLE && !any_req && !retx_due)
            idle_d = (idle_q == RETX_LIM) ? idle_q : idle_q + 32'd1;
    end

    // Idle counter and "a frame has been sent" flag.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            idle_q <= '0;
            sent_q <= 1'b0;
        end else begin
            idle_q <= idle_d;
            sent_q <= sent_d;
        end
    end
`endif

    // Next-state, counter reload and capture decisions.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_b_d  = last_b_q;
        val_d     = val_out;
        grant_a_d = 1'b0;
        grant_b_d = 1'b0;
        trig_d    = 1'b0;
`ifdef TX_SCHED_RETX_EN
        sent_d    = sent_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d   = SEND;
                    cnt_d     = FRAME_LOAD;
                    val_d     = win_a ? frame_a_in : frame_b_in;
                    last_b_d  = ~win_a;
                    grant_a_d = win_a;
                    grant_b_d = ~win_a;
                    trig_d    = 1'b1;
`ifdef TX_SCHED_RETX_EN
                    sent_d    = 1'b1;
                end else if (retx_due) begin
                    state_d   = SEND;
                    cnt_d     = FRAME_LOAD;
                    trig_d    = 1'b1;
`endif
                end
            end
            SEND: begin
                if (cnt_q == 24'd0) begin
                    if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                        cnt_d   = GAP_LOAD;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = 24'd0;
                    end
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            GAP: begin
                if (cnt_q == 24'd0) begin
                    state_d = IDLE;
                    cnt_d   = 24'd0;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 24'd0;
            end
        endcase
    end

    // State, counter and registered output pulses.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_b_q    <= 1'b1;
            val_out     <= '0;
            grant_a_out <= 1'b0;
            grant_b_out <= 1'b0;
            trigger_out <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_b_q    <= last_b_d;
            val_out     <= val_d;
            grant_a_out <= grant_a_d;
            grant_b_out <= grant_b_d;
            trigger_out <= trig_d;
        end
    end

    assign busy_out = (state_q != IDLE);

endmodule

// File: tb/tb_tx_sched.sv
// tb_tx_sched: random and directed stimulus against a timeline model.
// Honours TX_SCHED_RETX_EN when defined at compile time.
module tb_tx_sched;

    localparam int F = 20;
    localparam int G = 4;
    localparam int R = 50;
`ifdef TX_SCHED_RETX_EN
    localparam bit RETX = 1'b1;
`else
    localparam bit RETX = 1'b0;
`endif
    localparam logic [161:0] PAT = {2'h2, {40{4'hA}}};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_a = 1'b0, req_b = 1'b0;
    logic [161:0] frame_a = '0, frame_b = '0;
    logic         grant_a_out, grant_b_out, trigger_out, busy_out;
    logic [161:0] val_out;

    logic         rst0 = 1'b1;
    logic         ra0 = 1'b0, rb0 = 1'b0;
    logic [161:0] fa0 = '0, fb0 = '0;
    logic         grant_a0, grant_b0, trigger0, busy0;
    logic [161:0] val0;

    tx_sched #(.FRAME_CYCLES(F), .GAP_CYCLES(G), .RETX_CYCLES(R)) dut (
        .clk_in(clk), .rst_in(rst),
        .req_a_in(req_a), .frame_a_in(frame_a),
        .req_b_in(req_b), .frame_b_in(frame_b),
        .grant_a_out(grant_a_out), .grant_b_out(grant_b_out),
        .trigger_out(trigger_out), .val_out(val_out), .busy_out(busy_out)
    );

    tx_sched #(.FRAME_CYCLES(F), .GAP_CYCLES(0), .RETX_CYCLES(R)) dut0 (
        .clk_in(clk), .rst_in(rst0),
        .req_a_in(ra0), .frame_a_in(fa0),
        .req_b_in(rb0), .frame_b_in(fb0),
        .grant_a_out(grant_a0), .grant_b_out(grant_b0),
        .trigger_out(trigger0), .val_out(val0), .busy_out(busy0)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // Timeline model: the block is free from cycle idle_from onward.
    int           idle_from = 0;
    bit           m_last_b = 1'b1;
    bit           m_sent = 1'b0;
    logic [161:0] m_val = '0;
    bit           e_trig, e_ga, e_gb, e_busy;

    bit hold = 1'b0;
    int p_req = 0;
    int tq[$];
    int gq[$];
    int busy_n = 0;

    task automatic chk(input string tag, input logic [161:0] obs, input logic [161:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [161:0] rnd_frame();
        logic [191:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[161:0];
    endfunction

    function automatic int qat(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic model_edge();
        bit wa;
        e_trig = 1'b0;
        e_ga = 1'b0;
        e_gb = 1'b0;
        if (cyc >= idle_from) begin
            if (req_a || req_b) begin
                wa = req_a && (!req_b || m_last_b);
                m_val = wa ? frame_a : frame_b;
                m_last_b = !wa;
                m_sent = 1'b1;
                e_trig = 1'b1;
                e_ga = wa;
                e_gb = !wa;
                idle_from = cyc + 1 + F + G;
            end else if (RETX && m_sent && (cyc - idle_from + 1) == R) begin
                e_trig = 1'b1;
                idle_from = cyc + 1 + F + G;
            end
        end
        e_busy = (cyc + 1) < idle_from;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        chk("trigger", 162'(trigger_out), 162'(e_trig));
        chk("grant_a", 162'(grant_a_out), 162'(e_ga));
        chk("grant_b", 162'(grant_b_out), 162'(e_gb));
        chk("busy", 162'(busy_out), 162'(e_busy));
        chk("val", val_out, m_val);
        if (trigger_out) tq.push_back(cyc);
        if (grant_a_out) gq.push_back(1);
        if (grant_b_out) gq.push_back(2);
        if (busy_out) busy_n++;
        if (req_a && e_ga && !hold) req_a = 1'b0;
        else if (!req_a && $urandom_range(0, 99) < p_req) begin
            req_a = 1'b1;
            frame_a = rnd_frame();
        end
        if (req_b && e_gb && !hold) req_b = 1'b0;
        else if (!req_b && $urandom_range(0, 99) < p_req) begin
            req_b = 1'b1;
            frame_b = rnd_frame();
        end
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic clear_rec();
        tq.delete();
        gq.delete();
        busy_n = 0;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_outs", 162'({grant_a_out, grant_b_out, trigger_out, busy_out}), 162'(0));
        chk("rst_val", val_out, 162'(0));
        @(posedge clk);
        #1;
        chk("rst_hold", 162'({grant_a_out, grant_b_out, trigger_out, busy_out}), 162'(0));
        req_a = 1'b0;
        req_b = 1'b0;
        rst = 1'b0;
        cyc = 0;
        idle_from = 0;
        m_last_b = 1'b1;
        m_sent = 1'b0;
        m_val = '0;
    endtask

    initial begin
        int t0[$];
        int w0[$];
        logic [161:0] ev;
        @(posedge clk);
        #1;

        // Single request from A.
        do_reset();
        clear_rec();
        frame_a = PAT;
        req_a = 1'b1;
        run_to(30);
        chk("t028_trig_cyc", 162'(qat(tq, 0)), 162'(1));
        chk("t028_ntrig", 162'(tq.size()), 162'(1));
        chk("t028_busy_n", 162'(busy_n), 162'(24));
        chk("t028_val", val_out, PAT);
        chk("t028_winner", 162'(qat(gq, 0)), 162'(1));

        // Both requesting from reset: A, B, A every 25 cycles.
        do_reset();
        clear_rec();
        hold = 1'b1;
        frame_a = rnd_frame();
        frame_b = rnd_frame();
        req_a = 1'b1;
        req_b = 1'b1;
        run_to(60);
        hold = 1'b0;
        chk("t029_g0", 162'(qat(gq, 0)), 162'(1));
        chk("t029_g1", 162'(qat(gq, 1)), 162'(2));
        chk("t029_g2", 162'(qat(gq, 2)), 162'(1));
        chk("t029_sp1", 162'(qat(tq, 1) - qat(tq, 0)), 162'(25));
        chk("t029_sp2", 162'(qat(tq, 2) - qat(tq, 1)), 162'(25));

        // B arrives during A's frame and waits for the gap to end.
        do_reset();
        clear_rec();
        frame_a = rnd_frame();
        req_a = 1'b1;
        run_to(5);
        frame_b = rnd_frame();
        req_b = 1'b1;
        run_to(30);
        chk("t030_ntrig", 162'(tq.size()), 162'(2));
        chk("t030_b_cyc", 162'(qat(tq, 1)), 162'(26));
        chk("t030_b_win", 162'(qat(gq, 1)), 162'(2));

        // Reset in the middle of SEND.
        do_reset();
        clear_rec();
        frame_a = rnd_frame();
        req_a = 1'b1;
        run_to(10);
        do_reset();
        clear_rec();
        run_to(30);
        frame_b = rnd_frame();
        req_b = 1'b1;
        run_to(40);
        chk("t031_ntrig", 162'(tq.size()), 162'(1));
        chk("t031_trig_cyc", 162'(qat(tq, 0)), 162'(31));
        chk("t031_winner", 162'(qat(gq, 0)), 162'(2));

        // One frame, then a long quiet stretch.
        do_reset();
        clear_rec();
        frame_a = rnd_frame();
        req_a = 1'b1;
        run_to(1100);
        chk("t032_grants", 162'(gq.size()), 162'(1));
`ifdef TX_SCHED_RETX_EN
        chk("t032_retx_cyc", 162'(qat(tq, 1)), 162'(75));
`else
        chk("t032_ntrig", 162'(tq.size()), 162'(1));
`endif

        // Random request traffic.
        do_reset();
        clear_rec();
        p_req = 6;
        run_to(3000);
        p_req = 0;
        chk("rand_active", 162'(tq.size() > 20), 162'(1));

        // Zero-gap instance, back-to-back requests.
        fa0 = rnd_frame();
        fb0 = rnd_frame();
        #2 rst0 = 1'b1;
        @(posedge clk);
        #1;
        rst0 = 1'b0;
        ra0 = 1'b1;
        rb0 = 1'b1;
        for (int k = 1; k <= 70; k++) begin
            @(posedge clk);
            #1;
            if (trigger0) begin
                ev = (t0.size() % 2 == 0) ? fa0 : fb0;
                chk("g0_val", val0, ev);
                t0.push_back(k);
                w0.push_back(grant_a0 ? 1 : (grant_b0 ? 2 : 0));
            end
        end
        chk("g0_first", 162'(qat(t0, 0)), 162'(1));
        chk("g0_sp1", 162'(qat(t0, 1) - qat(t0, 0)), 162'(21));
        chk("g0_sp2", 162'(qat(t0, 2) - qat(t0, 1)), 162'(21));
        chk("g0_w0", 162'(qat(w0, 0)), 162'(1));
        chk("g0_w1", 162'(qat(w0, 1)), 162'(2));
        chk("g0_w2", 162'(qat(w0, 2)), 162'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_sched.md
TX_SCHED -- requirements
Module: tx_sched

Interface
REQ-001 Parameter FRAME_CYCLES, default 16200: clk_in cycles one tx frame occupies, counted from the trigger cycle; legal range 1..2^24-1.
REQ-002 Parameter GAP_CYCLES, default 1000: idle cycles enforced after each frame; 0 is legal.
REQ-003 Parameter RETX_CYCLES, default 1000000: idle cycles before an automatic resend; used only with TX_SCHED_RETX_EN.
REQ-004 clk_in  input  1  sole clock, rising-edge.
REQ-005 rst_in  input  1  reset, asynchronous and active-high.
REQ-006 req_a_in  input  1  requester A wants a frame sent; held high until grant_a_out is seen.
REQ-007 frame_a_in  input  162  requester A frame; stable while req_a_in is high.
REQ-008 req_b_in  input  1  requester B request, same rules as A.
REQ-009 frame_b_in  input  162  requester B frame.
REQ-010 grant_a_out  output  1  one-cycle pulse: A's frame was captured.
REQ-011 grant_b_out  output  1  one-cycle pulse: B's frame was captured.
REQ-012 trigger_out  output  1  one-cycle start pulse to the tx trigger_in.
REQ-013 val_out  output  162  frame held for tx val_in; stable from trigger until the next capture.
REQ-014 busy_out  output  1  high whenever the state is not IDLE.

Function
REQ-015 The block SHALL implement three states: IDLE, SEND and GAP.
REQ-016 In IDLE, at an edge sampling any request, the block SHALL capture the winning frame into val_out and enter SEND.
- Next cycle: grant_x_out=1 and trigger_out=1 together, one cycle only.
REQ-017 Arbitration SHALL be round-robin.
- Single request: that requester wins.
- Both requesting: the requester not granted last wins.
- After reset the last grant is B, so A wins the first tie.
REQ-018 SEND SHALL last exactly FRAME_CYCLES cycles, counting the trigger cycle; then GAP if GAP_CYCLES>0, else IDLE.
REQ-019 GAP SHALL last exactly GAP_CYCLES cycles, then IDLE.
REQ-020 Requests in SEND or GAP SHALL be ignored, with no grant and no loss; they are served from IDLE.
REQ-021 Minimum trigger-to-trigger spacing SHALL be FRAME_CYCLES+GAP_CYCLES+1 cycles.
REQ-022 val_out SHALL change only on a capture edge; trigger_out and the grants SHALL never be high outside the cycle after a capture.
REQ-023 The down-counter SHALL be 24 bits and SHALL never wrap; it is reloaded on each state entry.

Reset
REQ-024 While rst_in is high, asynchronously: state IDLE, trigger_out=0, grants=0, busy_out=0, val_out=0, counters=0, last grant=B, sent flag cleared.
REQ-025 Reset asserted mid-SEND or mid-GAP SHALL abort the frame with no further trigger.
- The first request after release SHALL be served with normal IDLE latency.

Configuration
REQ-026 With macro TX_SCHED_RETX_EN defined, the block SHALL count consecutive IDLE cycles with no request.
- When the count reaches RETX_CYCLES, at least one frame has been sent since reset, and no request is present, it SHALL enter SEND with val_out unchanged.
- It SHALL pulse trigger_out with no grant.
- Any request at the same edge SHALL win, and the idle count SHALL clear.
REQ-027 Without TX_SCHED_RETX_EN, the block SHALL generate no idle counter and no resend; the ports SHALL be identical.

Verification
Bench settings: FRAME_CYCLES=20, GAP_CYCLES=4, RETX_CYCLES=50.
REQ-028 A single request with frame_a_in=162'h2_AAAA...AAAA, raised at cycle 0, SHALL produce grant_a_out, trigger_out and that val_out in cycle 1, busy_out high for 24 cycles, and IDLE at cycle 25.
REQ-029 req_a_in and req_b_in held high together from reset SHALL produce grants in the order A, B, A, with triggers exactly 25 cycles apart.
REQ-030 req_b_in raised in cycle 5 of A's frame SHALL receive no grant before A's GAP ends; grant_b_out SHALL follow in cycle 26.
REQ-031 rst_in pulsed in cycle 10 of SEND SHALL give outputs 0 immediately and no trigger afterwards; a new request SHALL trigger one cycle after it is sampled.
REQ-032 With TX_SCHED_RETX_EN and one frame sent then no requests, trigger_out SHALL re-pulse 50 idle cycles after IDLE entry with the same val_out and no grant; without the macro, no pulse SHALL occur in 1000 cycles.
REQ-033 With GAP_CYCLES=0 and back-to-back requests, triggers SHALL be exactly 21 cycles apart.
